// File: rtl/fpga_i2c_pkg.sv
// Shared types and constants for the FPGA-side I2C target.
package fpga_i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_PTR,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } i2c_state_e;

  localparam logic ACK_BIT = 1'b0;

endpackage

// File: rtl/fpga_i2c_filter.sv
// Two-flop synchroniser plus a FILT_LEN-sample glitch filter with edge pulses
// that are registered together with the filtered level change.
module fpga_i2c_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILT_LEN) + 1;

  logic            sync_p0;
  logic            sync_p1;
  logic [CW-1:0]   cnt_q;

  // Bus idles high, so the synchroniser and filter reset to 1 to avoid a false edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      cnt_q   <= '0;
      filt_o  <= 1'b1;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
    end else begin
      sync_p0 <= raw_i;
      sync_p1 <= sync_p0;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
      if (sync_p1 == filt_o) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILT_LEN - 1)) begin
        cnt_q  <= '0;
        filt_o <= sync_p1;
        rise_o <= sync_p1;
        fall_o <= ~sync_p1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpga_i2c_target.sv
// I2C target exposing a byte-addressable register bank to the SoC's I2C0 master.
// Byte 0 of the bank is exported to fabric logic on reg0_o.
module fpga_i2c_target
  import fpga_i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h50,
  parameter int         DEPTH    = 16,
  parameter int         FILT_LEN = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] reg0_o,
  output logic       busy_o,
  output logic       wr_pulse_o
);

  localparam int PW = $clog2(DEPTH);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  fpga_i2c_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .raw_i  (scl_i),
    .filt_o (scl_f),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  fpga_i2c_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .raw_i  (sda_i),
    .filt_o (sda_f),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  i2c_state_e    state_q;
  logic [6:0]    sr_q;
  logic [3:0]    bit_cnt_q;
  logic          rw_q;
  logic [PW-1:0] ptr_q;
  logic [7:0]    bank_q [DEPTH];

  logic [7:0]    byte_in;
  logic [PW-1:0] ptr_nxt;
  logic          scl_before;
  logic          start_det;
  logic          stop_det;

  // The transmitted MSB goes straight to sda_oe_o, so only seven bits need holding.
  assign byte_in    = {sr_q, sda_f};
  assign ptr_nxt    = ptr_q + PW'(1);
  // SCL level before any simultaneous SCL edge decides START/STOP.
  assign scl_before = scl_rise ? 1'b0 : (scl_fall ? 1'b1 : scl_f);
  assign start_det  = sda_fall & scl_before;
  assign stop_det   = sda_rise & scl_before;
  assign reg0_o     = bank_q[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      rw_q       <= 1'b0;
      ptr_q      <= '0;
      sda_oe_o   <= 1'b0;
      busy_o     <= 1'b0;
      wr_pulse_o <= 1'b0;
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else begin
      wr_pulse_o <= 1'b0;
      if (start_det) begin
        state_q   <= ADDR;
        bit_cnt_q <= '0;
        sda_oe_o  <= 1'b0;
      end else if (stop_det) begin
        state_q  <= IDLE;
        sda_oe_o <= 1'b0;
        busy_o   <= 1'b0;
      end else begin
        case (state_q)
          ADDR: if (scl_rise) begin
            sr_q      <= byte_in[6:0];
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (byte_in[7:1] == I2C_ADDR) begin
                state_q <= ADDR_ACK;
                rw_q    <= byte_in[0];
                busy_o  <= 1'b1;
              end else begin
                state_q <= IGNORE;
              end
            end
          end
          // First falling edge starts the ACK, the second ends the 9th clock.
          ADDR_ACK: if (scl_fall) begin
            if (!sda_oe_o) begin
              sda_oe_o <= ~ACK_BIT;
            end else begin
              bit_cnt_q <= '0;
              if (rw_q) begin
                sr_q     <= bank_q[ptr_q][6:0];
                sda_oe_o <= ~bank_q[ptr_q][7];
                state_q  <= RD_DATA;
              end else begin
                sda_oe_o <= 1'b0;
                state_q  <= WR_PTR;
              end
            end
          end
          WR_PTR: begin
            if (scl_rise && bit_cnt_q < 4'd8) begin
              sr_q      <= byte_in[6:0];
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) ptr_q <= byte_in[PW-1:0];
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              if (!sda_oe_o) begin
                sda_oe_o <= ~ACK_BIT;
              end else begin
                sda_oe_o  <= 1'b0;
                bit_cnt_q <= '0;
                state_q   <= WR_DATA;
              end
            end
          end
          WR_DATA: if (scl_rise) begin
            sr_q      <= byte_in[6:0];
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bank_q[ptr_q] <= byte_in;
              wr_pulse_o    <= 1'b1;
              ptr_q         <= ptr_nxt;
              state_q       <= WR_ACK;
            end
          end
          WR_ACK: if (scl_fall) begin
            if (!sda_oe_o) begin
              sda_oe_o <= ~ACK_BIT;
            end else begin
              sda_oe_o  <= 1'b0;
              bit_cnt_q <= '0;
              state_q   <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe_o <= 1'b0;
                state_q  <= RD_ACK;
              end else begin
                sr_q     <= {sr_q[5:0], 1'b0};
                sda_oe_o <= ~sr_q[6];
              end
            end
          end
          // bit_cnt_q == 9 marks "master acknowledged, next byte due on the falling edge".
          RD_ACK: begin
            if (scl_rise) begin
              ptr_q <= ptr_nxt;
              if (sda_f == ACK_BIT) bit_cnt_q <= 4'd9;
              else                  state_q   <= IGNORE;
            end else if (scl_fall && bit_cnt_q == 4'd9) begin
              sr_q      <= bank_q[ptr_q][6:0];
              sda_oe_o  <= ~bank_q[ptr_q][7];
              bit_cnt_q <= '0;
              state_q   <= RD_DATA;
            end
          end
          default: sda_oe_o <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpga_i2c_target.sv
// Directed bench for fpga_i2c_target: an I2C master model drives the pins and
// compares ACKs, read data and the fabric-side outputs with hand-computed values.
module tb_fpga_i2c_target;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_i;
  logic       sda_oe_o;
  logic [7:0] reg0_o;
  logic       busy_o;
  logic       wr_pulse_o;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int oe_cnt = 0;

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] data;
    logic [7:0] exp_rd;
    logic [7:0] exp_reg0;
  } vec_t;

  vec_t vecs [4];

  assign sda_i = sda_m & ~sda_oe_o;

  fpga_i2c_target #(.I2C_ADDR(7'h50), .DEPTH(16), .FILT_LEN(3)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .scl_i      (scl_m),
    .sda_i      (sda_i),
    .sda_oe_o   (sda_oe_o),
    .reg0_o     (reg0_o),
    .busy_o     (busy_o),
    .wr_pulse_o (wr_pulse_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_pulse_o) pulse_cnt <= pulse_cnt + 1;
    if (sda_oe_o)   oe_cnt    <= oe_cnt + 1;
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    sda_m = 1'b0; wclk(Q);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    sda_m = 1'b1; wclk(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input bit glitch, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i];
      wclk(4);
      if (glitch) begin
        scl_m = 1'b1; wclk(1); scl_m = 1'b0; wclk(Q - 5);
      end else begin
        wclk(Q - 4);
      end
      scl_m = 1'b1; wclk(Q);
      if (glitch) begin
        scl_m = 1'b0; wclk(1); scl_m = 1'b1; wclk(Q - 1);
      end else begin
        wclk(Q);
      end
      scl_m = 1'b0; wclk(Q);
    end
    sda_m = 1'b1; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    ack = sda_i;
    wclk(Q);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wclk(Q);
      scl_m = 1'b1; wclk(Q);
      b[i] = sda_i;
      wclk(Q);
      scl_m = 1'b0; wclk(Q);
    end
    sda_m = nack; wclk(Q);
    scl_m = 1'b1; wclk(2 * Q);
    scl_m = 1'b0; wclk(2);
    sda_m = 1'b1; wclk(Q - 2);
  endtask

  task automatic write_xfer(input logic [7:0] p, input logic [7:0] d, output logic [2:0] acks);
    i2c_start();
    write_byte(8'hA0, 1'b0, acks[2]);
    write_byte(p, 1'b0, acks[1]);
    write_byte(d, 1'b0, acks[0]);
    i2c_stop();
  endtask

  task automatic read_one(input logic [7:0] p, output logic [7:0] d, output logic [2:0] acks);
    i2c_start();
    write_byte(8'hA0, 1'b0, acks[2]);
    write_byte(p, 1'b0, acks[1]);
    i2c_start();
    write_byte(8'hA1, 1'b0, acks[0]);
    read_byte(1'b1, d);
    i2c_stop();
  endtask

  initial begin
    logic [2:0] a3, r3;
    logic [3:0] a4;
    logic       a;
    logic [7:0] d0, d1;
    int         pc, oc, n;

    vecs[0] = '{8'h05, 8'hA5, 8'hA5, 8'h22};
    vecs[1] = '{8'h0A, 8'h3C, 8'h3C, 8'h22};
    vecs[2] = '{8'h00, 8'h81, 8'h81, 8'h81};
    vecs[3] = '{8'h1F, 8'h7E, 8'h7E, 8'h81};

    wclk(5);
    rst_ni = 1'b1;
    wclk(5);
    check("rst_sda_oe", sda_oe_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_wr_pulse", wr_pulse_o, 0);
    check("rst_reg0", reg0_o, 8'h00);

    // Single write to byte 0, busy sampled inside and after the transfer.
    pc = pulse_cnt;
    i2c_start();
    write_byte(8'hA0, 1'b0, a3[2]);
    check("wr_busy_mid", busy_o, 1);
    write_byte(8'h00, 1'b0, a3[1]);
    write_byte(8'h5A, 1'b0, a3[0]);
    i2c_stop();
    check("wr_acks", a3, 3'b000);
    check("wr_reg0", reg0_o, 8'h5A);
    check("wr_pulses", pulse_cnt - pc, 1);
    check("wr_busy_after", busy_o, 0);

    // Burst wrapping from 15 to 0.
    pc = pulse_cnt;
    i2c_start();
    write_byte(8'hA0, 1'b0, a4[3]);
    write_byte(8'h0F, 1'b0, a4[2]);
    write_byte(8'h11, 1'b0, a4[1]);
    write_byte(8'h22, 1'b0, a4[0]);
    i2c_stop();
    check("burst_acks", a4, 4'b0000);
    check("burst_reg0", reg0_o, 8'h22);
    check("burst_pulses", pulse_cnt - pc, 2);

    // Read across the wrap with a repeated START.
    i2c_start();
    write_byte(8'hA0, 1'b0, a3[2]);
    write_byte(8'h0F, 1'b0, a3[1]);
    i2c_start();
    write_byte(8'hA1, 1'b0, a3[0]);
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    oc = oe_cnt;
    wclk(3 * Q);
    check("rd_acks", a3, 3'b000);
    check("rd_byte0", d0, 8'h11);
    check("rd_byte1", d1, 8'h22);
    check("rd_released_after_nack", oe_cnt - oc, 0);
    i2c_stop();

    // Wrong address: no ACKs, no SDA drive, no bank change.
    pc = pulse_cnt;
    oc = oe_cnt;
    i2c_start();
    write_byte(8'hA2, 1'b0, a3[2]);
    check("badaddr_busy_mid", busy_o, 0);
    write_byte(8'h00, 1'b0, a3[1]);
    write_byte(8'h77, 1'b0, a3[0]);
    i2c_stop();
    check("badaddr_acks", a3, 3'b111);
    check("badaddr_oe_never", oe_cnt - oc, 0);
    check("badaddr_reg0", reg0_o, 8'h22);
    check("badaddr_pulses", pulse_cnt - pc, 0);

    // One-clock SCL glitches in both phases of every bit.
    pc = pulse_cnt;
    i2c_start();
    write_byte(8'hA0, 1'b1, a3[2]);
    write_byte(8'h03, 1'b1, a3[1]);
    write_byte(8'hC3, 1'b1, a3[0]);
    i2c_stop();
    check("glitch_acks", a3, 3'b000);
    check("glitch_pulses", pulse_cnt - pc, 1);
    read_one(8'h03, d0, r3);
    check("glitch_readback", d0, 8'hC3);

    for (int i = 0; i < 4; i++) begin
      pc = pulse_cnt;
      write_xfer(vecs[i].ptr, vecs[i].data, a3);
      check("tbl_wr_acks", a3, 3'b000);
      check("tbl_reg0", reg0_o, vecs[i].exp_reg0);
      check("tbl_pulses", pulse_cnt - pc, 1);
      read_one(vecs[i].ptr, d0, r3);
      check("tbl_rd_acks", r3, 3'b000);
      check("tbl_rd_data", d0, vecs[i].exp_rd);
    end

    // Pointer-only write, then a read that relies on the stored pointer.
    pc = pulse_cnt;
    i2c_start();
    write_byte(8'hA0, 1'b0, a3[2]);
    write_byte(8'h05, 1'b0, a3[1]);
    i2c_stop();
    i2c_start();
    write_byte(8'hA1, 1'b0, a3[0]);
    read_byte(1'b1, d0);
    i2c_stop();
    check("ptronly_acks", a3, 3'b000);
    check("ptronly_pulses", pulse_cnt - pc, 0);
    check("ptronly_data", d0, 8'hA5);

    // Reset while the target drives a 0 data bit (byte 0x3C at pointer 0x0A).
    i2c_start();
    write_byte(8'hA0, 1'b0, a3[2]);
    write_byte(8'h0A, 1'b0, a3[1]);
    i2c_start();
    write_byte(8'hA1, 1'b0, a3[0]);
    n = 0;
    while (!sda_oe_o && n < 200) begin
      wclk(1);
      n++;
    end
    check("rstmid_oe_driven", sda_oe_o, 1);
    rst_ni = 1'b0;
    #1;
    check("rstmid_oe_release", sda_oe_o, 0);
    check("rstmid_busy", busy_o, 0);
    check("rstmid_reg0", reg0_o, 8'h00);
    wclk(3);
    rst_ni = 1'b1;
    wclk(Q);
    i2c_stop();
    check("rstmid_idle_oe", sda_oe_o, 0);
    check("rstmid_idle_busy", busy_o, 0);

    write_xfer(8'h00, 8'h3C, a3);
    check("post_rst_acks", a3, 3'b000);
    check("post_rst_reg0", reg0_o, 8'h3C);
    read_one(8'h0F, d0, r3);
    check("post_rst_bank15", d0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
